multi_edge_detector: RTL and testbench

Parametrised, multi-channel successor to the single-bit edge detector. Each channel synchronises an asynchronous input, rejects glitches shorter than a programmable number of cycles, and produces one-cycle rising/falling pulses plus a mode-qualified event pulse. It also keeps a sticky flag and a wrapping event counter per channel. It sits between raw external inputs (buttons, strobes, interrupt lines) and the control logic that consumes their edges.

---
 rtl/multi_edge_detector.sv | 123 ++++++++++++
 tb/tb_multi_edge_detector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// multi_edge_detector
// Per-channel input conditioning: synchroniser, persistence filter, registered
// rise/fall pulses, mode-qualified event pulse, sticky flag and wrapping counter.
// Every channel is an independent slice; nothing is shared between channels
// except clk, rst and count_clr.

module multi_edge_detector #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       signal_in,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       sticky_clr,
    input  logic                      count_clr,
    output logic [CHANNELS-1:0]       pos_edge_out,
    output logic [CHANNELS-1:0]       neg_edge_out,
    output logic [CHANNELS-1:0]       event_pulse,
    output logic [CHANNELS-1:0]       event_sticky,
    output logic [CHANNELS*CNT_W-1:0] event_count
);

    // Run counter only needs to reach FILTER_CYCLES-1; keep at least one bit
    // so the FILTER_CYCLES=1 (no filtering) build still elaborates cleanly.
    localparam int FC_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] chain;
            logic                   sync;
            logic                   filt;
            logic                   filt_next;
            logic [FC_W-1:0]        run_cnt;
            logic [FC_W-1:0]        run_cnt_next;
            logic                   pos_q;
            logic                   neg_q;
            logic                   evt_q;
            logic                   sticky_q;
            logic [CNT_W-1:0]       count_q;

            assign sync = chain[SYNC_STAGES-1];

            // Synchroniser shift chain; bit 0 takes the raw asynchronous input.
            always_ff @(posedge clk) begin
                if (rst) begin
                    chain <= '0;
                end else begin
                    chain <= {chain[SYNC_STAGES-2:0], signal_in[i]};
                end
            end

            // Persistence filter: a differing level must hold for FILTER_CYCLES
            // consecutive edges before it replaces the accepted level.
            always_comb begin
                filt_next    = filt;
                run_cnt_next = '0;
                if (sync != filt) begin
                    if (run_cnt == FC_LAST) begin
                        filt_next = ~filt;
                    end else begin
                        run_cnt_next = run_cnt + 1'b1;
                    end
                end
            end

            // Accepted level, run counter and the edge pulses derived from them
            // all update together so the pulses line up with the filt change.
            always_ff @(posedge clk) begin
                if (rst) begin
                    filt    <= 1'b0;
                    run_cnt <= '0;
                    pos_q   <= 1'b0;
                    neg_q   <= 1'b0;
                    evt_q   <= 1'b0;
                end else begin
                    filt    <= filt_next;
                    run_cnt <= run_cnt_next;
                    pos_q   <= filt_next & ~filt;
                    neg_q   <= ~filt_next & filt;
                    evt_q   <= (filt_next & ~filt & mode[2*i]) |
                               (~filt_next & filt & mode[2*i+1]);
                end
            end

            // Sticky flag follows the registered event pulse; a coincident
            // clear loses so no event can be silently dropped.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sticky_q <= 1'b0;
                end else if (evt_q) begin
                    sticky_q <= 1'b1;
                end else if (sticky_clr[i]) begin
                    sticky_q <= 1'b0;
                end
            end

            // Wrapping event counter; a clear coincident with an event counts
            // that event, leaving 1.
            always_ff @(posedge clk) begin
                if (rst) begin
                    count_q <= '0;
                end else if (count_clr) begin
                    count_q <= evt_q ? CNT_ONE : '0;
                end else if (evt_q) begin
                    count_q <= count_q + CNT_ONE;
                end
            end

            assign pos_edge_out[i]                = pos_q;
            assign neg_edge_out[i]                = neg_q;
            assign event_pulse[i]                 = evt_q;
            assign event_sticky[i]                = sticky_q;
            assign event_count[CNT_W*i +: CNT_W]  = count_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed self-checking bench for multi_edge_detector (defaults, plus a
// CNT_W=2 instance sharing the same stimulus for the wrap case).

module tb_multi_edge_detector;

    logic       clk;
    logic       rst;
    logic [3:0] sig_in;
    logic [7:0] mode_v;
    logic [3:0] sclr;
    logic       cclr;

    logic [3:0]  pos, neg, evt, stk;
    logic [31:0] cnt;
    logic [3:0]  pos2, neg2, evt2, stk2;
    logic [7:0]  cnt2;

    int checks = 0;
    int errors = 0;

    int pos_n[4], neg_n[4], evt_r[4], evt_f[4], pos_at[4], neg_at[4];

    typedef struct {
        logic [3:0] sig;
        logic [3:0] pos;
        logic [3:0] neg;
        logic [3:0] evt;
        logic [3:0] stk;
        logic [7:0] cnt0;
    } vec_t;

    vec_t tbl[18];

    multi_edge_detector dut (
        .clk(clk), .rst(rst), .signal_in(sig_in), .mode(mode_v),
        .sticky_clr(sclr), .count_clr(cclr),
        .pos_edge_out(pos), .neg_edge_out(neg), .event_pulse(evt),
        .event_sticky(stk), .event_count(cnt)
    );

    multi_edge_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .signal_in(sig_in), .mode(mode_v),
        .sticky_clr(sclr), .count_clr(cclr),
        .pos_edge_out(pos2), .neg_edge_out(neg2), .event_pulse(evt2),
        .event_sticky(stk2), .event_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [3:0] hold);
        rst    = 1'b1;
        sig_in = hold;
        sclr   = '0;
        cclr   = 1'b0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_pos"}, 32'(pos), 32'h0);
        chk({name, "_neg"}, 32'(neg), 32'h0);
        chk({name, "_evt"}, 32'(evt), 32'h0);
        chk({name, "_stk"}, 32'(stk), 32'h0);
        chk({name, "_cnt"}, cnt, 32'h0);
    endtask

    // Drive mask for the first hi steps then zero; tally pulses per channel.
    task automatic run_seq(input logic [3:0] mask, input int hi, input int total);
        for (int c = 0; c < 4; c++) begin
            pos_n[c] = 0; neg_n[c] = 0; evt_r[c] = 0; evt_f[c] = 0;
            pos_at[c] = -1; neg_at[c] = -1;
        end
        for (int s = 0; s < total; s++) begin
            sig_in = (s < hi) ? mask : 4'h0;
            step();
            for (int c = 0; c < 4; c++) begin
                if (pos[c]) begin
                    pos_n[c]++;
                    if (pos_at[c] < 0) pos_at[c] = s;
                end
                if (neg[c]) begin
                    neg_n[c]++;
                    if (neg_at[c] < 0) neg_at[c] = s;
                end
                if (evt[c]) begin
                    if (s < hi + 5) evt_r[c]++;
                    else evt_f[c]++;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; sig_in = '0; mode_v = 8'hFF; sclr = '0; cclr = 1'b0;

        // Reset values
        do_reset(4'h0);
        chk_all_zero("reset");

        // Input held high through reset -> one pos pulse at edge 5 after release
        do_reset(4'h1);
        chk_all_zero("reset_held");
        run_seq(4'h1, 12, 12);
        chk("held_pos_count", 32'(pos_n[0]), 32'd1);
        chk("held_pos_at", 32'(pos_at[0]), 32'd5);

        // Basic edges, table-driven: ch0 high for 10 cycles then low
        for (int k = 0; k < 18; k++) begin
            tbl[k].sig  = (k < 10) ? 4'h1 : 4'h0;
            tbl[k].pos  = (k == 5) ? 4'h1 : 4'h0;
            tbl[k].neg  = (k == 15) ? 4'h1 : 4'h0;
            tbl[k].evt  = (k == 5 || k == 15) ? 4'h1 : 4'h0;
            tbl[k].stk  = (k >= 6) ? 4'h1 : 4'h0;
            tbl[k].cnt0 = (k >= 16) ? 8'd2 : (k >= 6) ? 8'd1 : 8'd0;
        end
        mode_v = 8'hFF;
        do_reset(4'h0);
        for (int k = 0; k < 18; k++) begin
            sig_in = tbl[k].sig;
            step();
            chk($sformatf("basic_pos[%0d]", k), 32'(pos), 32'(tbl[k].pos));
            chk($sformatf("basic_neg[%0d]", k), 32'(neg), 32'(tbl[k].neg));
            chk($sformatf("basic_evt[%0d]", k), 32'(evt), 32'(tbl[k].evt));
            chk($sformatf("basic_stk[%0d]", k), 32'(stk), 32'(tbl[k].stk));
            chk($sformatf("basic_cnt0[%0d]", k), 32'(cnt[7:0]), 32'(tbl[k].cnt0));
            chk($sformatf("basic2_pos[%0d]", k), 32'(pos2), 32'(tbl[k].pos));
            chk($sformatf("basic2_neg[%0d]", k), 32'(neg2), 32'(tbl[k].neg));
            chk($sformatf("basic2_evt[%0d]", k), 32'(evt2), 32'(tbl[k].evt));
            chk($sformatf("basic2_stk[%0d]", k), 32'(stk2), 32'(tbl[k].stk));
            chk($sformatf("basic2_cnt0[%0d]", k), 32'(cnt2[1:0]), 32'(tbl[k].cnt0[1:0]));
        end

        // Glitch rejection on ch1
        do_reset(4'h0);
        run_seq(4'h2, 3, 14);
        chk("glitch3_pos", 32'(pos_n[1]), 32'd0);
        chk("glitch3_neg", 32'(neg_n[1]), 32'd0);
        chk("glitch3_cnt1", 32'(cnt[15:8]), 32'd0);
        run_seq(4'h2, 4, 14);
        chk("pulse4_pos", 32'(pos_n[1]), 32'd1);
        chk("pulse4_neg", 32'(neg_n[1]), 32'd1);
        chk("pulse4_pos_at", 32'(pos_at[1]), 32'd5);
        chk("pulse4_neg_at", 32'(neg_at[1]), 32'd9);
        chk("pulse4_cnt1", 32'(cnt[15:8]), 32'd2);

        // Mode qualification: ch3 fall, ch2 rise, ch1/ch0 off
        mode_v = 8'b10_01_00_00;
        do_reset(4'h0);
        run_seq(4'b1101, 6, 20);
        chk("mode_pos0", 32'(pos_n[0]), 32'd1);
        chk("mode_neg0", 32'(neg_n[0]), 32'd1);
        chk("mode_pos2", 32'(pos_n[2]), 32'd1);
        chk("mode_neg3", 32'(neg_n[3]), 32'd1);
        chk("mode_evt0", 32'(evt_r[0] + evt_f[0]), 32'd0);
        chk("mode_evt2_rise", 32'(evt_r[2]), 32'd1);
        chk("mode_evt2_fall", 32'(evt_f[2]), 32'd0);
        chk("mode_evt3_rise", 32'(evt_r[3]), 32'd0);
        chk("mode_evt3_fall", 32'(evt_f[3]), 32'd1);
        chk("mode_sticky", 32'(stk), 32'hC);
        chk("mode_count", cnt, 32'h0101_0000);

        // Sticky / counter races on ch0
        mode_v = 8'hFF;
        do_reset(4'h0);
        sig_in = 4'h1;
        repeat (8) step();
        chk("race_pre_stk", 32'(stk[0]), 32'd1);
        chk("race_pre_cnt", 32'(cnt[7:0]), 32'd1);
        sig_in = 4'h0;
        repeat (5) step();
        sclr = 4'h1;
        cclr = 1'b1;
        step();
        chk("race_L_evt", 32'(evt[0]), 32'd1);
        chk("race_L_stk", 32'(stk[0]), 32'd0);
        chk("race_L_cnt", 32'(cnt[7:0]), 32'd0);
        step();
        chk("race_L1_stk", 32'(stk[0]), 32'd1);
        chk("race_L1_cnt", 32'(cnt[7:0]), 32'd1);
        sclr = 4'h0;
        cclr = 1'b0;
        step();
        chk("race_after_stk", 32'(stk[0]), 32'd1);
        chk("race_after_cnt", 32'(cnt[7:0]), 32'd1);

        // Counter wrap: five events, CNT_W=8 gives 5, CNT_W=2 gives 1
        do_reset(4'h0);
        for (int e = 0; e < 5; e++) begin
            sig_in = (e % 2 == 0) ? 4'h1 : 4'h0;
            repeat (8) step();
        end
        chk("wrap_cnt8", 32'(cnt[7:0]), 32'd5);
        chk("wrap_cnt2", 32'(cnt2[1:0]), 32'd1);

        // Mid-filter reset: pending run count must be discarded
        do_reset(4'h0);
        sig_in = 4'h1;
        repeat (4) step();
        rst = 1'b1;
        step();
        chk_all_zero("midrst");
        step();
        rst = 1'b0;
        run_seq(4'h1, 12, 12);
        chk("midrst_pos_count", 32'(pos_n[0]), 32'd1);
        chk("midrst_pos_at", 32'(pos_at[0]), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
